// File: rtl/bus_rr.sv
// Shared-bus interconnect: round-robin arbitration across masters, address decode to
// a one-hot slave select, and registered read/decode-error responses tagged with the master id.
module bus_rr #(
  parameter int NUM_MASTERS = 3,
  parameter int NUM_SLAVES  = 8,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MAX_HOLD    = 0,
  localparam int SB  = (NUM_SLAVES  > 1) ? $clog2(NUM_SLAVES)  : 1,
  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MASTERS-1:0]       m_req,
  input  logic [NUM_MASTERS-1:0]       m_wr,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]       m_grant,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-1:0]            s_addr,
  output logic                         s_wr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_rvalid,
  output logic [MIW-1:0]               m_rid,
  output logic                         m_err
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  // Hold counter saturates at the rotation threshold so a late-arriving requester still forces a handover.
  localparam logic [HW-1:0]  CNT_SAT  = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b1}};
  localparam logic [MIW-1:0] LAST_RST = MIW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e                 state_q, state_d;
  logic [MIW-1:0]         owner_q, owner_d;
  logic [MIW-1:0]         last_q, last_d;
  logic [HW-1:0]          cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic [NUM_MASTERS-1:0] others_req;
  logic                   force_rot;
  logic                   pick_found;
  logic [MIW-1:0]         pick_idx;
  int                     cand;
  logic [MIW-1:0]         cand_idx;

  assign others_req = m_req & ~(NUM_MASTERS'(1) << owner_q);
  assign force_rot  = (MAX_HOLD > 0) && (state_q == OWNED) && (cnt_q == CNT_SAT) && (|others_req);

  // Round-robin scan starting just after the last winner; a forced rotation skips the owner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand     = (int'(last_q) + i) % NUM_MASTERS;
      cand_idx = MIW'(cand);
      if (!pick_found && m_req[cand_idx] && !(force_rot && (cand_idx == owner_q))) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if ((state_q == OWNED) && m_req[owner_q] && !force_rot) begin
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
    end else if (pick_found) begin
      state_d = OWNED;
      owner_d = pick_idx;
      last_d  = pick_idx;
      cnt_d   = '0;
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    grant_d = '0;
    if (state_d == OWNED) grant_d = NUM_MASTERS'(1) << owner_d;
  end

  logic              active;
  logic [SB-1:0]     slv_idx;
  logic              dec_ok;
  logic              rd_fire;
  logic              err_fire;
  logic [DATA_W-1:0] rd_sel;

  assign active = (state_q == OWNED) && m_req[owner_q];

  always_comb begin
    s_addr  = '0;
    s_wr    = 1'b0;
    s_wdata = '0;
    if (active) begin
      s_addr  = m_addr[int'(owner_q)*ADDR_W +: ADDR_W];
      s_wr    = m_wr[owner_q];
      s_wdata = m_wdata[int'(owner_q)*DATA_W +: DATA_W];
    end
  end

  generate
    if (NUM_SLAVES == 1) begin : g_single
      assign slv_idx = '0;
    end else begin : g_multi
      assign slv_idx = s_addr[ADDR_W-1 -: SB];
    end
  endgenerate

  assign dec_ok   = int'(slv_idx) < NUM_SLAVES;
  assign s_sel    = (active && dec_ok) ? (NUM_SLAVES'(1) << slv_idx) : '0;
  assign rd_fire  = active && !s_wr && dec_ok;
  assign err_fire = active && !dec_ok;

  always_comb begin
    rd_sel = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (slv_idx == SB'(j)) rd_sel = s_rdata[j*DATA_W +: DATA_W];
    end
  end

  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic [MIW-1:0]    rid_q;
  logic              err_q;

  // Response registers: rdata and rid only move when a response is actually issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rd_fire;
      err_q    <= err_fire;
      if (rd_fire) rdata_q <= rd_sel;
      if (rd_fire || err_fire) rid_q <= owner_q;
    end
  end

  assign m_grant  = grant_q;
  assign m_rdata  = rdata_q;
  assign m_rvalid = rvalid_q;
  assign m_rid    = rid_q;
  assign m_err    = err_q;

endmodule

// File: tb/tb_bus_rr.sv
// Directed bench for bus_rr: instance a (8 slaves, MAX_HOLD=4) and instance b
// (6 slaves, unlimited hold) share the same master/slave stimulus.
module tb_bus_rr;

  logic         clk;
  logic         reset;
  logic [2:0]   m_req;
  logic [2:0]   m_wr;
  logic [23:0]  m_addr;
  logic [95:0]  m_wdata;
  logic [255:0] s_rdata;

  logic [2:0]  a_grant, b_grant;
  logic [7:0]  a_sel;
  logic [5:0]  b_sel;
  logic [7:0]  a_addr, b_addr;
  logic        a_wr, b_wr;
  logic [31:0] a_wdata, b_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid;
  logic [1:0]  a_rid, b_rid;
  logic        a_err, b_err;

  int passed = 0;
  int total  = 0;

  bus_rr #(.NUM_MASTERS(3), .NUM_SLAVES(8), .ADDR_W(8), .DATA_W(32), .MAX_HOLD(4)) u_a (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_grant(a_grant), .s_sel(a_sel), .s_addr(a_addr),
    .s_wr(a_wr), .s_wdata(a_wdata), .s_rdata(s_rdata), .m_rdata(a_rdata),
    .m_rvalid(a_rvalid), .m_rid(a_rid), .m_err(a_err)
  );

  bus_rr #(.NUM_MASTERS(3), .NUM_SLAVES(6), .ADDR_W(8), .DATA_W(32), .MAX_HOLD(0)) u_b (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_grant(b_grant), .s_sel(b_sel), .s_addr(b_addr),
    .s_wr(b_wr), .s_wdata(b_wdata), .s_rdata(s_rdata[191:0]), .m_rdata(b_rdata),
    .m_rvalid(b_rvalid), .m_rid(b_rid), .m_err(b_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [2:0] exp_g;
    reset   = 1'b1;
    m_req   = 3'b000;
    m_wr    = 3'b000;
    m_addr  = {8'h64, 8'h25, 8'h00};
    m_wdata = {32'h2222_2222, 32'hDEADBEEF, 32'h0000_0000};
    for (int j = 0; j < 8; j++) s_rdata[j*32 +: 32] = 32'hA000_0000 + 32'(j);
    s_rdata[3*32 +: 32] = 32'h1234_5678;
    s_rdata[6*32 +: 32] = 32'hC0FF_EE06;

    tick(); tick();
    chk("rst_grant",  32'(a_grant),  32'h0);
    chk("rst_rvalid", 32'(a_rvalid), 32'h0);
    chk("rst_err",    32'(a_err),    32'h0);
    chk("rst_rdata",  a_rdata,       32'h0);
    chk("rst_rid",    32'(a_rid),    32'h0);

    reset = 1'b0;
    m_req = 3'b111;
    tick();
    chk("first_grant_a", 32'(a_grant), 32'h1);
    chk("first_grant_b", 32'(b_grant), 32'h1);
    chk("m0_sel",        32'(a_sel),   32'h01);
    tick();
    chk("m0_rvalid", 32'(a_rvalid), 32'h1);
    chk("m0_rdata",  a_rdata,       32'hA000_0000);

    // Reset lands while a read response is on the bus.
    reset = 1'b1;
    #1;
    chk("midrst_grant",  32'(a_grant),  32'h0);
    chk("midrst_rvalid", 32'(a_rvalid), 32'h0);
    chk("midrst_err",    32'(a_err),    32'h0);
    chk("midrst_rdata",  a_rdata,       32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("postrst_grant", 32'(a_grant), 32'h1);

    tick();
    chk("rr_m0_rv1",   32'(a_rvalid), 32'h1);
    chk("rr_m0_rid",   32'(a_rid),    32'h0);
    tick();
    chk("rr_m0_rv2",   32'(a_rvalid), 32'h1);
    m_req = 3'b110;
    m_wr  = 3'b010;
    #1;
    chk("drop_sel",   32'(a_sel),   32'h0);
    chk("drop_addr",  32'(a_addr),  32'h0);
    chk("drop_grant", 32'(a_grant), 32'h1);

    tick();
    chk("rr_grant_m1", 32'(a_grant),  32'h2);
    chk("drop_rvalid", 32'(a_rvalid), 32'h0);
    m_req = 3'b111;
    #1;
    chk("wr_sel",   32'(a_sel),  32'h02);
    chk("wr_addr",  32'(a_addr), 32'h25);
    chk("wr_wr",    32'(a_wr),   32'h1);
    chk("wr_wdata", a_wdata,     32'hDEADBEEF);
    tick();
    chk("wr_rvalid", 32'(a_rvalid), 32'h0);
    chk("wr_err",    32'(a_err),    32'h0);
    m_req = 3'b101;

    tick();
    chk("rr_grant_m2", 32'(a_grant), 32'h4);
    m_req = 3'b111;
    #1;
    chk("rd_sel",  32'(a_sel),  32'h08);
    chk("rd_addr", 32'(a_addr), 32'h64);
    tick();
    chk("rd_rdata",  a_rdata,       32'h1234_5678);
    chk("rd_rvalid", 32'(a_rvalid), 32'h1);
    chk("rd_rid",    32'(a_rid),    32'h2);
    tick();
    chk("rd_rvalid2", 32'(a_rvalid), 32'h1);
    chk("rd_rid2",    32'(a_rid),    32'h2);
    m_req = 3'b011;

    tick();
    chk("rr_wrap_a", 32'(a_grant), 32'h1);
    chk("rr_wrap_b", 32'(b_grant), 32'h1);

    // Two masters requesting continuously: a rotates every 4 cycles, b never rotates.
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = (k < 4) ? 3'b001 : ((k < 8) ? 3'b010 : 3'b001);
      chk($sformatf("hold_a_%0d", k), 32'(a_grant), 32'(exp_g));
      chk($sformatf("hold_b_%0d", k), 32'(b_grant), 32'h1);
    end

    m_req = 3'b001;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("solo_a_%0d", k), 32'(a_grant), 32'h1);
    end
    m_req = 3'b011;
    tick();
    chk("sat_force_a", 32'(a_grant), 32'h2);
    chk("sat_keep_b",  32'(b_grant), 32'h1);

    m_req = 3'b001;
    m_wr  = 3'b000;
    m_addr[7:0] = 8'hC0;
    #1;
    chk("err_sel_b",  32'(b_sel), 32'h0);
    chk("idle_sel_a", 32'(a_sel), 32'h0);
    tick();
    chk("err_pulse_b",  32'(b_err),    32'h1);
    chk("err_rvalid_b", 32'(b_rvalid), 32'h0);
    chk("err_rid_b",    32'(b_rid),    32'h0);
    chk("err_rdata_b",  b_rdata,       32'hA000_0000);
    chk("c0_grant_a",   32'(a_grant),  32'h1);
    chk("c0_sel_a",     32'(a_sel),    32'h40);
    tick();
    chk("c0_rvalid_a",  32'(a_rvalid), 32'h1);
    chk("c0_rdata_a",   a_rdata,       32'hC0FF_EE06);
    chk("err_pulse2_b", 32'(b_err),    32'h1);
    m_req = 3'b000;
    tick();
    chk("idle_grant_a", 32'(a_grant), 32'h0);
    chk("idle_grant_b", 32'(b_grant), 32'h0);
    chk("idle_err_b",   32'(b_err),   32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_rr.md
Name: bus_rr

Overview:
Parametrised shared-bus interconnect with NUM_MASTERS masters and NUM_SLAVES slaves. A round-robin arbiter grants one master at a time, with an optional maximum-hold limit. Address decode drives a one-hot slave select. Read data and decode errors return registered, tagged with the master index. It is the next-generation bus fabric: no fixed priority, no default master, no embedded memory (slaves are external).

Parameters:
NUM_MASTERS, 3, number of masters (2..8)
NUM_SLAVES, 8, number of slave regions (1..16)
ADDR_W, 8, address width
DATA_W, 32, data width
MAX_HOLD, 0, max consecutive grant cycles while others wait; 0 = unlimited
(derived) SB = max(1,clog2(NUM_SLAVES)); MIW = max(1,clog2(NUM_MASTERS))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
m_req  in  NUM_MASTERS  per-master request; while granted, also qualifies a transfer
m_wr  in  NUM_MASTERS  per-master write(1)/read(0)
m_addr  in  NUM_MASTERS*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  NUM_MASTERS*DATA_W  master write data, packed like m_addr
m_grant  out  NUM_MASTERS  registered one-hot grant (all 0 when idle)
s_sel  out  NUM_SLAVES  one-hot slave select, combinational
s_addr  out  ADDR_W  granted master address
s_wr  out  1  granted master write strobe
s_wdata  out  DATA_W  granted master write data
s_rdata  in  NUM_SLAVES*DATA_W  slave read data, slave j at [j*DATA_W +: DATA_W]
m_rdata  out  DATA_W  registered read data
m_rvalid  out  1  one-cycle pulse: m_rdata valid
m_rid  out  MIW  master index for m_rvalid/m_err
m_err  out  1  one-cycle pulse: decode error

Behaviour:
- Reset (async, immediate):
  - m_grant=0, m_rdata=0, m_rvalid=0, m_rid=0, m_err=0.
  - Hold counter=0. RR pointer last=NUM_MASTERS-1, so master 0 wins the first arbitration.
- Arbiter state: owner index, owner_valid (IDLE/OWNED), last, hold counter. Evaluated every rising edge.
  - OWNED and m_req[owner]=1 and no forced rotation: keep owner; counter increments and saturates.
  - Otherwise: pick the first requester scanning last+1, last+2, … modulo NUM_MASTERS.
    - If found: owner=that master, last=that master, counter=0.
    - If none: IDLE, m_grant=0.
  - Forced rotation: MAX_HOLD>0, counter==MAX_HOLD-1, and another master requesting. The owner is excluded from that scan.
  - If no other requester exists, the owner keeps the bus regardless of MAX_HOLD.
- Grant latency:
  - Request in cycle T with bus idle → m_grant in cycle T+1.
  - Handover A→B is direct (no idle grant cycle). B is granted the cycle after A's request drops, or after A's hold expires.
- Transfer:
  - Active in a cycle iff m_grant[k]=1 and m_req[k]=1.
  - If m_req[k] drops while granted, that cycle is not a transfer: s_sel=0, s_wr=0.
- Bus outputs (combinational):
  - Active: s_addr/s_wr/s_wdata come from the owner.
  - Inactive: s_sel=0, s_addr=0, s_wr=0, s_wdata=0.
- Decode:
  - idx = s_addr[ADDR_W-1 -: SB]; NUM_SLAVES=1 → idx=0.
  - idx<NUM_SLAVES → s_sel=1<<idx.
  - Otherwise s_sel=0 and the transfer is a decode error.
- Read return:
  - Active decoded read in cycle T: s_rdata[idx] is captured at the end of T.
  - Cycle T+1: m_rdata = captured data, m_rvalid=1, m_rid=owner.
  - m_rdata holds its value when m_rvalid=0.
  - Back-to-back reads give back-to-back m_rvalid pulses.
- Write: no response on success.
- Decode error (read or write): m_err=1 with m_rid=owner in T+1. m_rvalid stays 0 and m_rdata is unchanged.
- Reset mid-transfer: pending m_rvalid/m_err are discarded.
- Simultaneous request drop and new requests: resolved by the RR scan in the same edge.

Test Plan:
- Reset: assert reset during an active read (NUM_MASTERS=3) → m_grant=0, m_rvalid=0, m_err=0 immediately. After release with m_req=3'b111 → m_grant=3'b001 one cycle later.
- Round-robin: m_req=3'b111; each owner drops its req for one cycle after 2 transfers → grant sequence 001→010→100→001, no idle grant cycle between owners.
- Max hold: MAX_HOLD=4, m_req=3'b011 held constantly → m_grant alternates 01/10 every 4 cycles. With m_req=3'b001 only, m0 holds indefinitely.
- Write decode: NUM_SLAVES=8, m1 granted, m_wr=1, addr 0x25, wdata 0xDEADBEEF → same cycle s_sel=8'h02, s_addr=8'h25, s_wr=1, s_wdata=32'hDEADBEEF. m_rvalid stays 0.
- Read return: m2 reads 0x64 with slave 3 driving 0x12345678 → next cycle m_rdata=32'h12345678, m_rvalid=1, m_rid=2. Two consecutive reads → two consecutive pulses.
- Decode error: NUM_SLAVES=6, read addr 0xC0 (idx 6) → s_sel=0, next cycle m_err=1, m_rvalid=0, m_rdata unchanged.
